// File: rtl/sub16_serial.sv
// Nibble-serial 16-bit subtractor: X - Y computed as X + ~Y + 1, one 4-bit
// carry-lookahead slice per clock, LSB nibble first, with result flags.
module sub16_serial (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] X,
   input  logic [15:0] Y,
   output logic        busy,
   output logic        done,
   output logic [15:0] Z,
   output logic        Sign,
   output logic        Zero,
   output logic        Carry,
   output logic        Parity,
   output logic        Overflow
);

   localparam int unsigned W  = 16;
   localparam int unsigned NW = 4;
   localparam int unsigned CW = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [W-1:0]    xr;
   logic [W-1:0]    yr;
   logic [W-1:0]    part;
   logic [CW-1:0]   cnt;
   logic            cy;

   logic [NW-1:0]   a;
   logic [NW-1:0]   b;
   logic [NW-1:0]   g;
   logic [NW-1:0]   p;
   logic [NW:0]     c;
   logic [NW-1:0]   sum;
   logic [W-1:0]    full;
   logic [3:0]      base;

   // One carry-lookahead nibble slice on the currently selected operand nibble
   always_comb begin
      base = {cnt, 2'b00};
      a    = xr[base +: NW];
      b    = ~yr[base +: NW];
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cy;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum  = p ^ c[NW-1:0];
      full = {sum, part[W-NW-1:0]};
   end

   // Control FSM, operand capture, nibble accumulation and result/flag load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         xr       <= '0;
         yr       <= '0;
         part     <= '0;
         cnt      <= '0;
         cy       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Z        <= '0;
         Sign     <= 1'b0;
         Zero     <= 1'b0;
         Carry    <= 1'b0;
         Parity   <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  xr    <= X;
                  yr    <= Y;
                  cnt   <= '0;
                  cy    <= 1'b1;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               part[base +: NW] <= sum;
               cy               <= c[NW];
               cnt              <= cnt + CW'(1);
               if (cnt == CW'(3)) begin
                  Z        <= full;
                  Sign     <= full[W-1];
                  Zero     <= (full == '0);
                  Carry    <= c[NW];
                  Parity   <= ~^full;
                  Overflow <= (xr[W-1] != yr[W-1]) & (full[W-1] != xr[W-1]);
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub16_serial.sv
// Directed table-driven bench for sub16_serial with hand-written sequences
// for start re-pulse, restart from DONE and reset mid-operation.
module tb_sub16_serial;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] X;
   logic [15:0] Y;
   logic        busy;
   logic        done;
   logic [15:0] Z;
   logic        Sign;
   logic        Zero;
   logic        Carry;
   logic        Parity;
   logic        Overflow;

   int n_pass;
   int n_total;

   sub16_serial dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .X        (X),
      .Y        (Y),
      .busy     (busy),
      .done     (done),
      .Z        (Z),
      .Sign     (Sign),
      .Zero     (Zero),
      .Carry    (Carry),
      .Parity   (Parity),
      .Overflow (Overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags packed as {Sign, Zero, Carry, Parity, Overflow}
   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic [4:0]  f;
   } vec_t;

   function automatic logic [4:0] flags();
      return {Sign, Zero, Carry, Parity, Overflow};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Caller is at a falling edge; start is accepted at the next rising edge
   task automatic run_op(input vec_t v, input string tag);
      logic        lat_ok;
      logic [15:0] zprev;
      zprev = Z;
      X = v.x; Y = v.y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat_ok = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         if (!(busy === 1'b1 && done === 1'b0 && Z === zprev)) lat_ok = 1'b0;
         @(negedge clk);
      end
      chk({tag, " run_window"}, 32'(lat_ok), 32'd1);
      chk({tag, " busy_done"}, 32'({busy, done}), 32'b01);
      chk({tag, " Z"}, 32'(Z), 32'(v.z));
      chk({tag, " flags"}, 32'(flags()), 32'(v.f));
   endtask

   vec_t vecs[8];

   initial begin
      vec_t v;
      logic seen_done;
      n_pass  = 0;
      n_total = 0;
      rst_n = 1'b0; start = 1'b0; X = '0; Y = '0;

      //            x        y        z          S Z C P O
      vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 5'b00100};
      vecs[1] = '{16'h0003, 16'h0005, 16'hFFFE, 5'b10000};
      vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 5'b00101};
      vecs[3] = '{16'h1234, 16'h1234, 16'h0000, 5'b01110};
      vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 5'b10001};
      vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 5'b01110};
      vecs[6] = '{16'h00FF, 16'h000F, 16'h00F0, 5'b00110};
      vecs[7] = '{16'h0001, 16'h0002, 16'hFFFF, 5'b10010};

      repeat (2) @(negedge clk);
      chk("reset busy_done", 32'({busy, done}), 32'd0);
      chk("reset Z", 32'(Z), 32'd0);
      chk("reset flags", 32'(flags()), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
         @(negedge clk);
      end

      // start re-pulsed with other operands during RUN is ignored
      X = 16'hFFFF; Y = 16'h0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0; X = 16'h1111; Y = 16'h2222;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("repulse done", 32'({busy, done}), 32'b01);
      chk("repulse Z", 32'(Z), 32'hFFFE);
      // start held in DONE restarts immediately
      X = 16'h0005; Y = 16'h0003; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart busy_done", 32'({busy, done}), 32'b10);
      chk("restart Z hold", 32'(Z), 32'hFFFE);
      repeat (4) @(negedge clk);
      chk("restart Z", 32'(Z), 32'h0002);
      chk("restart flags", 32'(flags()), 32'b00100);
      @(negedge clk);

      // reset two cycles after start aborts with no done pulse
      X = 16'h0003; Y = 16'h0005; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy_done", 32'({busy, done}), 32'd0);
      chk("abort Z", 32'(Z), 32'd0);
      chk("abort flags", 32'(flags()), 32'd0);
      seen_done = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
      end
      chk("abort quiet", 32'(seen_done), 32'd0);
      rst_n = 1'b1;
      v = '{16'h8000, 16'h0001, 16'h7FFF, 5'b00101};
      run_op(v, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sub16_serial.md
SUB16_SERIAL -- requirements
Module: sub16_serial

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  asynchronous reset, active-low.
REQ-003 start  input  1  request to subtract; sampled on rising clk edges.
REQ-004 X  input  16  minuend; sampled only on the accepting edge.
REQ-005 Y  input  16  subtrahend; sampled only on the accepting edge.
REQ-006 busy  output  1  high while a subtraction is in progress.
REQ-007 done  output  1  one-cycle pulse; Z and flags are updated when it asserts.
REQ-008 Z  output  16  registered result X-Y, two's complement, modulo 2^16.
REQ-009 Sign  output  1  Z[15] of the last completed operation.
REQ-010 Zero  output  1  1 when the last Z==0.
REQ-011 Carry  output  1  carry-out of X+~Y+1; 1 = no borrow (X>=Y unsigned).
REQ-012 Parity  output  1  even parity, ~^Z: 1 when Z has an even number of ones.
REQ-013 Overflow  output  1  signed overflow: (X[15]!=Y[15]) & (Z[15]!=X[15]).

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE with start=1 at an edge, the block SHALL capture X and Y, clear the nibble counter, set the internal carry to 1, and enter RUN.
REQ-016 start SHALL be ignored while in RUN, and captured operands SHALL NOT change mid-operation.
REQ-017 In RUN, each edge SHALL compute one 4-bit nibble k (k=0..3, LSB first) as X[4k+3:4k] + ~Y[4k+3:4k] + carry, using 4-bit carry-lookahead logic (g=a&b, p=a^b).
REQ-018 Each RUN edge SHALL store the nibble into an internal partial-result register and store the nibble carry-out as the next carry.
REQ-019 On the edge that computes nibble 3, the block SHALL load Z and all five flags from the full 16-bit result and final carry, then enter DONE.
REQ-020 DONE SHALL last exactly one cycle unless start=1 restarts the block, and SHALL otherwise return to IDLE.
REQ-021 Latency: with start accepted at edge E0, busy SHALL be 1 after E0 through E4, and done SHALL be 1 only in the cycle after E4; back-to-back operations SHALL complete every 5 cycles.
REQ-022 busy SHALL be 1 exactly in RUN, and done SHALL be 1 exactly in DONE.
REQ-023 Z and the flags SHALL hold their values from the last completion until the next completion, including during RUN.
REQ-024 Partial results SHALL NOT be visible on Z.
REQ-025 The nibble counter SHALL be 2 bits, and its wrap from 3 SHALL coincide with the RUN to DONE transition.

Reset
REQ-026 While rst_n=0, regardless of clk, the FSM SHALL be IDLE, and busy, done, Z, Sign, Zero, Carry, Parity and Overflow SHALL all be 0.
REQ-027 While rst_n=0, the internal counter, carry and operand registers SHALL be 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and Z and flags SHALL read 0.
REQ-029 The first edge after rst_n rises SHALL be able to accept start.

Verification
REQ-030 The bench SHALL cover: X=0x0005, Y=0x0003 -> done at E0+5, Z=0x0002, Carry=1, Sign=0, Zero=0, Parity=0, Overflow=0.
REQ-031 The bench SHALL cover: X=0x0003, Y=0x0005 -> Z=0xFFFE, Carry=0, Sign=1, Zero=0, Parity=0, Overflow=0.
REQ-032 The bench SHALL cover: X=0x8000, Y=0x0001 -> Z=0x7FFF, Overflow=1, Carry=1, Sign=0, Parity=0.
REQ-033 The bench SHALL cover: X=0x1234, Y=0x1234 -> Z=0x0000, Zero=1, Carry=1, Parity=1, Sign=0, Overflow=0.
REQ-034 The bench SHALL cover: start=1 with X=0xFFFF, Y=0x0001 re-pulsed during RUN with other operands -> single result Z=0xFFFE; then start held high in DONE -> new operation accepted, busy=1 on the next cycle.
REQ-035 The bench SHALL cover: rst_n=0 two cycles after start -> busy=0, done never pulses, Z=0, all flags 0; the next start after release completes normally in 5 cycles.
